// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
package reset_seq_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_HOLD     = 3'd0,
      ST_WAIT_ACK = 3'd1,
      ST_GAP      = 3'd2,
      ST_RUN      = 3'd3,
      ST_FAULT    = 3'd4
   } seq_state_e;

   localparam int unsigned DefNumDomains   = 3;
   localparam int unsigned DefPowerOnDelay = 50000000;
   localparam int unsigned DefStageDelay   = 1000;
   localparam int unsigned DefAckTimeout   = 100000;

   // Largest of three delays, used to size the shared timer
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Clearable up-counter with an equality terminal-count flag.
module reset_seq_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [Width-1:0] i_term,
   output logic             o_tc_c
);

   logic [Width-1:0] r_count;

   // Count register: clear wins over increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + Width'(1);
      end
   end

   assign o_tc_c = (r_count == i_term);

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains one at a time, waiting for each to
// acknowledge, and falls back to FAULT if an acknowledge is late or lost.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned NumDomains   = DefNumDomains,
   parameter int unsigned PowerOnDelay = DefPowerOnDelay,
   parameter int unsigned StageDelay   = DefStageDelay,
   parameter int unsigned AckTimeout   = DefAckTimeout,
   parameter int unsigned TimerWidth   =
      $clog2(max3(PowerOnDelay, StageDelay, AckTimeout) + 1),
   localparam int unsigned IdxWidth    = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  soft_req,
   input  logic [NumDomains-1:0] dom_ready,
   output logic [NumDomains-1:0] dom_rst,
   output logic                  all_ready,
   output logic                  fault,
   output logic [IdxWidth-1:0]   cur_idx
);

   localparam logic [IdxWidth-1:0]   LastIdx   = IdxWidth'(NumDomains - 1);
   localparam logic [NumDomains-1:0] AllOnes   = {NumDomains{1'b1}};
   localparam logic [TimerWidth-1:0] TermHold  = TimerWidth'(PowerOnDelay - 1);
   localparam logic [TimerWidth-1:0] TermAck   = TimerWidth'(AckTimeout - 1);
   localparam logic [TimerWidth-1:0] TermStage = TimerWidth'(StageDelay - 1);

   seq_state_e              r_state;
   seq_state_e              w_nxt_state;
   logic [NumDomains-1:0]   r_dom_rst;
   logic [NumDomains-1:0]   w_nxt_dom_rst;
   logic                    r_all_ready;
   logic                    w_nxt_all_ready;
   logic                    r_fault;
   logic                    w_nxt_fault;
   logic [IdxWidth-1:0]     r_cur_idx;
   logic [IdxWidth-1:0]     w_nxt_idx;
   logic                    w_tmr_clr;
   logic                    w_tmr_en;
   logic                    w_tmr_tc;
   logic [TimerWidth-1:0]   w_term;

   // Terminal count selected by the state currently being timed
   always_comb begin
      w_term = '0;
      case (r_state)
         ST_HOLD:     w_term = TermHold;
         ST_WAIT_ACK: w_term = TermAck;
         ST_GAP:      w_term = TermStage;
         default:     w_term = '0;
      endcase
   end

   reset_seq_timer #(
      .Width (TimerWidth)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_tmr_clr),
      .i_en   (w_tmr_en),
      .i_term (w_term),
      .o_tc_c (w_tmr_tc)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_HOLD;
         r_dom_rst   <= AllOnes;
         r_all_ready <= 1'b0;
         r_fault     <= 1'b0;
         r_cur_idx   <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_dom_rst   <= w_nxt_dom_rst;
         r_all_ready <= w_nxt_all_ready;
         r_fault     <= w_nxt_fault;
         r_cur_idx   <= w_nxt_idx;
      end
   end

   // Next-state, next-output and timer control; soft_req overrides everything
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_dom_rst   = r_dom_rst;
      w_nxt_all_ready = r_all_ready;
      w_nxt_fault     = r_fault;
      w_nxt_idx       = r_cur_idx;
      w_tmr_clr       = 1'b0;
      w_tmr_en        = 1'b0;

      case (r_state)
         ST_HOLD: begin
            if (w_tmr_tc) begin
               w_nxt_dom_rst[r_cur_idx] = 1'b0;
               w_nxt_state              = ST_WAIT_ACK;
               w_tmr_clr                = 1'b1;
            end else begin
               w_tmr_en = 1'b1;
            end
         end

         ST_WAIT_ACK: begin
            if (dom_ready[r_cur_idx]) begin
               w_tmr_clr = 1'b1;
               if (r_cur_idx == LastIdx) begin
                  w_nxt_state     = ST_RUN;
                  w_nxt_all_ready = 1'b1;
               end else begin
                  w_nxt_state = ST_GAP;
               end
            end else if (w_tmr_tc) begin
               w_tmr_clr       = 1'b1;
               w_nxt_state     = ST_FAULT;
               w_nxt_dom_rst   = AllOnes;
               w_nxt_all_ready = 1'b0;
               w_nxt_fault     = 1'b1;
            end else begin
               w_tmr_en = 1'b1;
            end
         end

         ST_GAP: begin
            if (w_tmr_tc) begin
               w_nxt_idx                = r_cur_idx + IdxWidth'(1);
               w_nxt_dom_rst[w_nxt_idx] = 1'b0;
               w_nxt_state              = ST_WAIT_ACK;
               w_tmr_clr                = 1'b1;
            end else begin
               w_tmr_en = 1'b1;
            end
         end

         ST_RUN: begin
            if (dom_ready != AllOnes) begin
               w_tmr_clr       = 1'b1;
               w_nxt_state     = ST_FAULT;
               w_nxt_dom_rst   = AllOnes;
               w_nxt_all_ready = 1'b0;
               w_nxt_fault     = 1'b1;
            end
         end

         ST_FAULT: begin
            w_nxt_state = ST_FAULT;
         end

         default: begin
            w_nxt_state     = ST_HOLD;
            w_nxt_dom_rst   = AllOnes;
            w_nxt_all_ready = 1'b0;
            w_nxt_fault     = 1'b0;
            w_nxt_idx       = '0;
            w_tmr_clr       = 1'b1;
         end
      endcase

      if (soft_req) begin
         w_nxt_state     = ST_HOLD;
         w_nxt_dom_rst   = AllOnes;
         w_nxt_all_ready = 1'b0;
         w_nxt_fault     = 1'b0;
         w_nxt_idx       = '0;
         w_tmr_clr       = 1'b1;
         w_tmr_en        = 1'b0;
      end
   end

   assign dom_rst   = r_dom_rst;
   assign all_ready = r_all_ready;
   assign fault     = r_fault;
   assign cur_idx   = r_cur_idx;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NumDomains, default 3: number of downstream reset domains, released in index order 0..NumDomains-1.
REQ-002 Parameter PowerOnDelay, default 50000000: cycles held in HOLD before domain 0 is released.
REQ-003 Parameter StageDelay, default 1000: gap cycles between a domain's ready and the next domain's release.
REQ-004 Parameter AckTimeout, default 100000: cycles allowed for a released domain to assert ready.
REQ-005 Parameter TimerWidth, default $clog2(max(PowerOnDelay,StageDelay,AckTimeout)+1): shared timer width.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 soft_req  input  1  synchronous request to re-run the whole sequence; level-sampled each edge.
REQ-009 dom_ready  input  NumDomains  per-domain "out of reset and alive" acknowledge, already synchronous to clk.
REQ-010 dom_rst  output  NumDomains  per-domain reset, active-high, registered.
REQ-011 all_ready  output  1  high while in RUN; registered.
REQ-012 fault  output  1  high while in FAULT; registered.
REQ-013 cur_idx  output  $clog2(NumDomains)  index of domain currently being released or awaited.

Function
REQ-014 States: HOLD, WAIT_ACK, GAP, RUN, FAULT; one shared timer, cleared on every state change.
REQ-015 HOLD: timer increments each edge; on the edge where timer==PowerOnDelay-1, clear dom_rst[cur_idx], enter WAIT_ACK.
REQ-016 WAIT_ACK: if dom_ready[cur_idx]==1 and cur_idx==NumDomains-1, enter RUN with all_ready=1 on that edge.
REQ-017 WAIT_ACK: if dom_ready[cur_idx]==1 and cur_idx<NumDomains-1, enter GAP.
REQ-018 WAIT_ACK: else if timer==AckTimeout-1, enter FAULT; else timer increments.
REQ-019 GAP: on the edge where timer==StageDelay-1, increment cur_idx, clear dom_rst[new cur_idx], enter WAIT_ACK; else timer increments.
REQ-020 Released domains stay released; dom_rst bits only go 1->0 in index order, never out of order.
REQ-021 RUN: if any dom_ready bit drops to 0, enter FAULT.
REQ-022 Entering FAULT: all dom_rst bits set to 1, all_ready=0, fault=1; FAULT is left only via soft_req or rst.
REQ-023 soft_req==1 on any edge, any state, has priority over all other transitions: all dom_rst=1, all_ready=0, fault=0, cur_idx=0, timer=0, enter HOLD.
REQ-024 soft_req held high keeps the block in HOLD with timer at 0; the sequence starts after soft_req falls.
REQ-025 Timer compare uses equality against the parameter minus one at TimerWidth bits; no wrap-around is reachable.
REQ-026 Degenerate values: StageDelay==1 or AckTimeout==1 behave per the rules above, with no special case.

Reset
REQ-027 rst low asynchronously forces: dom_rst all 1, all_ready=0, fault=0, cur_idx=0, timer=0, state HOLD.
REQ-028 rst asserted mid-sequence (any state) takes effect without a clock edge; the sequence restarts from HOLD after release.

Structure
REQ-029 Package reset_seq_pkg holds the state enum and the default parameter constants.
REQ-030 One sub-module, reset_seq_timer: a clearable up-counter with an equality terminal-count output, instantiated once.

Verification (NumDomains=3, PowerOnDelay=8, StageDelay=4, AckTimeout=16; edge N = Nth rising edge after rst release)
REQ-031 Nominal case, dom_ready follows dom_rst inverted with no delay:
- dom_rst[0] falls after edge 8.
- dom_rst[1] falls after edge 13.
- dom_rst[2] falls after edge 18.
- all_ready=1 after edge 19.
REQ-032 Timeout case, dom_ready[1] held 0: after edge 29, fault=1, dom_rst=3'b111, all_ready=0; the block stays in FAULT for 100 further edges.
REQ-033 Soft restart: soft_req pulsed for one cycle while in RUN -> on the next edge dom_rst=3'b111 and all_ready=0; the release edges then repeat the nominal offsets relative to that edge.
REQ-034 Lost ready: dom_ready[0] dropped while in RUN -> on the next edge fault=1 and dom_rst=3'b111; a following soft_req clears fault and restarts the sequence.
REQ-035 Asynchronous reset: rst pulled low mid-GAP between clock edges -> dom_rst=3'b111, cur_idx=0, fault=0 immediately; after rst release, dom_rst[0] falls after edge 8.
REQ-036 soft_req held high for 20 cycles -> dom_rst stays 3'b111 throughout; dom_rst[0] falls 8 edges after soft_req falls.
